// File: rtl/booth2_pp1_decoder_if.sv
// Handshake bundle for the first-row Booth-2 partial-product decoder.
// Master drives the Booth code and operands, slave returns the product.
interface booth2_pp1_decoder_if #(
  parameter int A_W = 16
);
  logic           in_valid;
  logic [1:0]     code_2bit;
  logic [A_W-1:0] A;
  logic [A_W:0]   inversed_A;
  logic [A_W+1:0] pp_out;
  logic           out_valid;

  modport master (
    output in_valid,
    output code_2bit,
    output A,
    output inversed_A,
    input  pp_out,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  code_2bit,
    input  A,
    input  inversed_A,
    output pp_out,
    output out_valid
  );
endinterface

// File: rtl/booth2_pp1_decoder.sv
// Radix-4 Booth decoder for the least-significant partial product.
// Selects 0/+A/-2A/-A and registers the word with its sign inverted.
module booth2_pp1_decoder #(
  parameter int A_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  booth2_pp1_decoder_if.slave  bus
);

  localparam int PW = A_W + 2;
  localparam logic [PW-1:0] ENC_ZERO =
    {1'b1, {(PW-1){1'b0}}};

  logic          sel_pos;
  logic          sel_neg2;
  logic          sel_neg;
  logic [PW-1:0] p;
  logic [PW-1:0] enc;
  logic [PW-1:0] pp_q;
  logic          vld_q;

  // Implicit B[-1]=0 leaves only three non-zero codes.
  always_comb begin
    sel_pos  = bus.in_valid &&
               (bus.code_2bit == 2'b01);
    sel_neg2 = bus.in_valid &&
               (bus.code_2bit == 2'b10);
    sel_neg  = bus.in_valid &&
               (bus.code_2bit == 2'b11);
  end

  always_comb begin
    p = '0;
    unique case (1'b1)
      sel_pos:
        p = {{2{bus.A[A_W-1]}}, bus.A};
      sel_neg2:
        p = {bus.inversed_A, 1'b0};
      sel_neg:
        p = {bus.inversed_A[A_W],
             bus.inversed_A};
      default:
        p = '0;
    endcase
  end

  assign enc = {~p[PW-1], p[PW-2:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      pp_q  <= ENC_ZERO;
      vld_q <= 1'b0;
    end else begin
      vld_q <= bus.in_valid;
      if (bus.in_valid)
        pp_q <= enc;
    end
  end

  assign bus.pp_out    = pp_q;
  assign bus.out_valid = vld_q;

endmodule

// File: tb/tb_booth2_pp1_decoder.sv
// Randomised self-checking bench for booth2_pp1_decoder.
// Reference model works on signed integers, then encodes the sign.
module tb_booth2_pp1_decoder;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  booth2_pp1_decoder_if #(.A_W(16)) bus ();

  booth2_pp1_decoder #(.A_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [16:0] neg_a(
    input logic [15:0] a
  );
    int signed n;
    n = -int'($signed(a));
    return n[16:0];
  endfunction

  function automatic logic [17:0] model(
    input logic [1:0]  c,
    input logic [15:0] a
  );
    int signed av;
    int signed p;
    logic [17:0] w;
    av = int'($signed(a));
    case (c)
      2'd0:    p = 0;
      2'd1:    p = av;
      2'd2:    p = -2 * av;
      default: p = -av;
    endcase
    w = p[17:0];
    return w ^ 18'h20000;
  endfunction

  task automatic drive(
    input logic        v,
    input logic [1:0]  c,
    input logic [15:0] a,
    input logic [16:0] ia
  );
    bus.in_valid   = v;
    bus.code_2bit  = c;
    bus.A          = a;
    bus.inversed_A = ia;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       nm,
    input logic [17:0] exp_pp,
    input logic        exp_v
  );
    tests++;
    if (bus.pp_out !== exp_pp) begin
      fails++;
      $display("FAIL %s pp_out got %h want %h",
               nm, bus.pp_out, exp_pp);
    end
    tests++;
    if (bus.out_valid !== exp_v) begin
      fails++;
      $display("FAIL %s out_valid got %b want %b",
               nm, bus.out_valid, exp_v);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 2'b01, 16'h1234, neg_a(16'h1234));
    tick();
    tick();
    chk("reset", 18'h20000, 1'b0);
    rst = 1'b0;
    drive(1'b0, 2'b00, 16'h0, 17'h0);
    tick();
  endtask

  task automatic test_vectors();
    logic [15:0] av [2];
    logic [16:0] iv [2];
    logic [17:0] ev [2][4];
    av[0] = 16'h5C0B;
    iv[0] = 17'h1A3F5;
    av[1] = 16'h8000;
    iv[1] = 17'h08000;
    ev[0][0] = 18'h20000;
    ev[0][1] = 18'h25C0B;
    ev[0][2] = 18'h147EA;
    ev[0][3] = 18'h1A3F5;
    ev[1][0] = 18'h20000;
    ev[1][1] = 18'h18000;
    ev[1][2] = 18'h30000;
    ev[1][3] = 18'h28000;
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < 4; c++) begin
        drive(1'b1, 2'(c), av[i], iv[i]);
        tick();
        chk($sformatf("vec%0d_code%0d", i, c),
            ev[i][c], 1'b1);
      end
    end
    drive(1'b0, 2'b00, 16'h0, 17'h0);
    tick();
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [1:0]  c;
    for (int i = 0; i < 300; i++) begin
      a = 16'($urandom);
      if (i % 50 == 0) a = 16'h8000;
      if (i % 50 == 1) a = 16'h7FFF;
      if (i % 50 == 2) a = 16'hFFFF;
      c = 2'($urandom_range(0, 3));
      drive(1'b1, c, a, neg_a(a));
      tick();
      chk($sformatf("rand%0d", i),
          model(c, a), 1'b1);
    end
  endtask

  task automatic test_reset_midstream();
    logic [15:0] a;
    a = 16'h3A5C;
    drive(1'b1, 2'b10, a, neg_a(a));
    tick();
    chk("mid_pre", model(2'b10, a), 1'b1);
    rst = 1'b1;
    drive(1'b1, 2'b01, 16'h4321, neg_a(16'h4321));
    tick();
    chk("mid_rst", 18'h20000, 1'b0);
    rst = 1'b0;
    a = 16'hC001;
    drive(1'b1, 2'b11, a, neg_a(a));
    tick();
    chk("mid_post", model(2'b11, a), 1'b1);
  endtask

  task automatic test_hold();
    logic [15:0] a;
    logic [17:0] last;
    a = 16'h0F0F;
    drive(1'b1, 2'b01, a, neg_a(a));
    tick();
    last = model(2'b01, a);
    chk("hold_src", last, 1'b1);
    for (int i = 0; i < 3; i++) begin
      a = 16'($urandom);
      drive(1'b0, 2'($urandom), a, neg_a(a));
      tick();
      chk($sformatf("hold%0d", i), last, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] a;
    logic [1:0]  c;
    for (int i = 0; i < 8; i++) begin
      a = 16'($urandom);
      c = 2'(i);
      drive(1'b1, c, a, neg_a(a));
      tick();
      chk($sformatf("b2b%0d", i),
          model(c, a), 1'b1);
    end
    drive(1'b0, 2'b00, 16'h0, 17'h0);
    tick();
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_end out_valid got %b want 0",
               bus.out_valid);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 2'b00, 16'h0, 17'h0);
    test_reset();
    test_vectors();
    test_random();
    test_reset_midstream();
    test_hold();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
